// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC request path.
// The tag width depends on CORDIC_SWEEP_EN, which adds the internal sweep requester.
package cordic_pkg;

    localparam int PHASE_W = 18;
    localparam int OFFS_W  = 16;
    localparam int ANG_W   = 9;

    localparam logic [1:0] Q1 = 2'b00;
    localparam logic [1:0] Q2 = 2'b01;
    localparam logic [1:0] Q3 = 2'b10;
    localparam logic [1:0] Q4 = 2'b11;

    localparam logic [ANG_W-1:0] ANG_90  = 9'd90;
    localparam logic [ANG_W-1:0] ANG_180 = 9'd180;
    localparam logic [ANG_W-1:0] ANG_270 = 9'd270;
    localparam logic [ANG_W-1:0] ANG_359 = 9'd359;
    localparam logic [ANG_W-1:0] ANG_360 = 9'd360;

`ifdef CORDIC_SWEEP_EN
    localparam int TAG_W = 2;
`else
    localparam int TAG_W = 1;
`endif

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_CH0 = tag_t'(0);
    localparam tag_t TAG_CH1 = tag_t'(1);
`ifdef CORDIC_SWEEP_EN
    localparam tag_t TAG_SWEEP = tag_t'(2);
`endif

    typedef struct packed {
        logic vld;
        tag_t tag;
    } track_t;

    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_DRAIN} sweep_state_t;

endpackage

// File: rtl/cordic_req_arbiter_if.sv
// Request, core and response signals of cordic_req_arbiter.
// slave = arbiter side, master = requesters plus core side; CORDIC_SWEEP_EN adds sweep signals.
interface cordic_req_arbiter_if #(
    parameter int DATA_W = 32
);
    import cordic_pkg::*;

    logic               req0_valid;
    logic [ANG_W-1:0]   req0_angle;
    logic               req0_ready;
    logic               req1_valid;
    logic [ANG_W-1:0]   req1_angle;
    logic               req1_ready;
    logic [PHASE_W-1:0] phase;
    logic               phase_vld;
    logic [DATA_W-1:0]  cordic_sin;
    logic [DATA_W-1:0]  cordic_cos;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic [DATA_W-1:0]  rsp_sin;
    logic [DATA_W-1:0]  rsp_cos;
`ifdef CORDIC_SWEEP_EN
    logic               sweep_start;
    logic               sweep_busy;
    logic               rsp_sweep_valid;
`endif

    modport slave (
`ifdef CORDIC_SWEEP_EN
        input  sweep_start,
        output sweep_busy, rsp_sweep_valid,
`endif
        input  req0_valid, req0_angle, req1_valid, req1_angle, cordic_sin, cordic_cos,
        output req0_ready, req1_ready, phase, phase_vld,
        output rsp0_valid, rsp1_valid, rsp_sin, rsp_cos
    );

    modport master (
`ifdef CORDIC_SWEEP_EN
        output sweep_start,
        input  sweep_busy, rsp_sweep_valid,
`endif
        output req0_valid, req0_angle, req1_valid, req1_angle, cordic_sin, cordic_cos,
        input  req0_ready, req1_ready, phase, phase_vld,
        input  rsp0_valid, rsp1_valid, rsp_sin, rsp_cos
    );

endinterface

// File: rtl/angle_to_phase.sv
// Whole-degree angle (0..511) to quadrant-encoded CORDIC phase {quadrant, offset}.
// Purely combinational; also used by the phase generators.
module angle_to_phase
    import cordic_pkg::*;
(
    input  logic [ANG_W-1:0]   angle,
    output logic [PHASE_W-1:0] phase
);

    logic [ANG_W-1:0] a;
    logic [ANG_W-1:0] offs;
    logic [1:0]       quad;

    always_comb begin
        // NOTE: every variable gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
        a    = (angle >= ANG_360) ? angle - ANG_360 : angle;
        quad = Q1;
        offs = a;
        if (a > ANG_270) begin
            quad = Q4;
            offs = a - ANG_270;
        end else if (a > ANG_180) begin
            quad = Q3;
            offs = a - ANG_180;
        end else if (a > ANG_90) begin
            quad = Q2;
            offs = a - ANG_90;
        end
        phase = {quad, {(OFFS_W - ANG_W){1'b0}}, offs};
    end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin sharing of one CORDIC core between ch0/ch1, with in-flight tag tracking.
// Define CORDIC_SWEEP_EN to add a lowest-priority 0..359 degree sweep requester.
module cordic_req_arbiter
    import cordic_pkg::*;
#(
    parameter int CORDIC_LAT = 16,
    parameter int DATA_W     = 32
) (
    input logic                 clk,
    input logic                 rst,
    cordic_req_arbiter_if.slave bus
);

    logic               rr_last;
    logic               grant0;
    logic               grant1;
    logic               grant_any;
    logic [ANG_W-1:0]   sel_angle;
    tag_t               sel_tag;
    logic [PHASE_W-1:0] next_phase;
    logic [PHASE_W-1:0] phase_q;
    logic               phase_vld_q;
    tag_t               phase_tag;
    track_t             dl [CORDIC_LAT];
    track_t             dl_out;
    logic               rsp0_q;
    logic               rsp1_q;
    logic [DATA_W-1:0]  rsp_sin_q;
    logic [DATA_W-1:0]  rsp_cos_q;
`ifdef CORDIC_SWEEP_EN
    sweep_state_t       sw_state;
    logic [ANG_W-1:0]   sw_angle;
    logic               sw_busy_q;
    logic               rsp_sw_q;
    logic               grant_sw;
    logic               line_busy;
`endif

    assign dl_out = dl[CORDIC_LAT-1];

    always_comb begin
        grant0    = bus.req0_valid && (!bus.req1_valid || rr_last);
        grant1    = bus.req1_valid && (!bus.req0_valid || !rr_last);
        sel_angle = bus.req0_angle;
        sel_tag   = TAG_CH0;
        if (grant1) begin
            sel_angle = bus.req1_angle;
            sel_tag   = TAG_CH1;
        end
`ifdef CORDIC_SWEEP_EN
        grant_sw = (sw_state == SW_RUN) && !bus.req0_valid && !bus.req1_valid;
        if (grant_sw) begin
            sel_angle = sw_angle;
            sel_tag   = TAG_SWEEP;
        end
        grant_any = grant0 || grant1 || grant_sw;
`else
        grant_any = grant0 || grant1;
`endif
    end

    angle_to_phase u_angle_to_phase (
        .angle (sel_angle),
        .phase (next_phase)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last     <= 1'b1;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            phase_tag   <= TAG_CH0;
            // NOTE: the tracking line is reset, unlike a data RAM, so work in flight across a reset never responds.
            for (int i = 0; i < CORDIC_LAT; i++) dl[i] <= '0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
            rsp_sin_q   <= '0;
            rsp_cos_q   <= '0;
`ifdef CORDIC_SWEEP_EN
            rsp_sw_q    <= 1'b0;
`endif
        end else begin
            if (grant0) rr_last <= 1'b0;
            else if (grant1) rr_last <= 1'b1;
            phase_vld_q <= grant_any;
            if (grant_any) begin
                phase_q   <= next_phase;
                phase_tag <= sel_tag;
            end
            dl[0] <= '{vld: phase_vld_q, tag: phase_tag};
            for (int i = 1; i < CORDIC_LAT; i++) dl[i] <= dl[i-1];
            rsp0_q <= dl_out.vld && (dl_out.tag == TAG_CH0);
            rsp1_q <= dl_out.vld && (dl_out.tag == TAG_CH1);
`ifdef CORDIC_SWEEP_EN
            rsp_sw_q <= dl_out.vld && (dl_out.tag == TAG_SWEEP);
`endif
            if (dl_out.vld) begin
                rsp_sin_q <= bus.cordic_sin;
                rsp_cos_q <= bus.cordic_cos;
            end
        end
    end

`ifdef CORDIC_SWEEP_EN
    always_comb begin
        line_busy = phase_vld_q;
        for (int i = 0; i < CORDIC_LAT; i++) line_busy = line_busy || dl[i].vld;
    end

    // Sweep stays busy through DRAIN until every issued phase has left the tracking line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_state  <= SW_IDLE;
            sw_angle  <= '0;
            sw_busy_q <= 1'b0;
        end else begin
            case (sw_state)
                SW_IDLE: if (bus.sweep_start) begin
                    sw_state  <= SW_RUN;
                    sw_angle  <= '0;
                    sw_busy_q <= 1'b1;
                end
                SW_RUN: if (grant_sw) begin
                    if (sw_angle == ANG_359) sw_state <= SW_DRAIN;
                    else sw_angle <= sw_angle + 9'd1;
                end
                SW_DRAIN: if (!line_busy) begin
                    sw_state  <= SW_IDLE;
                    sw_busy_q <= 1'b0;
                end
                default: sw_state <= SW_IDLE;
            endcase
        end
    end

    assign bus.sweep_busy      = sw_busy_q;
    assign bus.rsp_sweep_valid = rsp_sw_q;
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.phase      = phase_q;
    assign bus.phase_vld  = phase_vld_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_sin    = rsp_sin_q;
    assign bus.rsp_cos    = rsp_cos_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a delayed-identity core model (sin = phase, cos = ~phase).
// The sweep section is compiled only when CORDIC_SWEEP_EN is defined.
module tb_cordic_req_arbiter;
    import cordic_pkg::*;

    localparam int LAT = 16;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int            rsp_cyc [$];
    int            rsp_tag [$];
    logic [DW-1:0] rsp_dat [$];
    logic [DW-1:0] rsp_cs  [$];
    logic [DW-1:0] core_pipe [LAT];

    cordic_req_arbiter_if #(.DATA_W(DW)) bus ();

    cordic_req_arbiter #(.CORDIC_LAT(LAT), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        core_pipe[0] <= DW'(bus.phase);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end

    assign bus.cordic_sin = core_pipe[LAT-1];
    assign bus.cordic_cos = ~core_pipe[LAT-1];

    always @(negedge clk) begin
        if (bus.rsp0_valid) begin
            rsp_cyc.push_back(cyc); rsp_tag.push_back(0);
            rsp_dat.push_back(bus.rsp_sin); rsp_cs.push_back(bus.rsp_cos);
        end
        if (bus.rsp1_valid) begin
            rsp_cyc.push_back(cyc); rsp_tag.push_back(1);
            rsp_dat.push_back(bus.rsp_sin); rsp_cs.push_back(bus.rsp_cos);
        end
`ifdef CORDIC_SWEEP_EN
        if (bus.rsp_sweep_valid) begin
            rsp_cyc.push_back(cyc); rsp_tag.push_back(2);
            rsp_dat.push_back(bus.rsp_sin); rsp_cs.push_back(bus.rsp_cos);
        end
`endif
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rsp_cyc.delete(); rsp_tag.delete(); rsp_dat.delete(); rsp_cs.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

`ifdef CORDIC_SWEEP_EN
    function automatic logic [DW-1:0] model_phase(input int deg);
        int a;
        int q;
        a = deg % 360;
        q = (a == 0) ? 0 : (a - 1) / 90;
        return DW'((q << 16) | (a - 90 * q));
    endfunction
`endif

    initial begin
        int               t;
        logic [ANG_W-1:0] ang    [10];
        logic [17:0]      exp_ph [10];
`ifdef CORDIC_SWEEP_EN
        int               n_sw;
        int               bad_sw;
        int               last_sw;
        int               low_cyc;
        int               n_r0;
        logic             done;
`endif

        bus.req0_valid = 1'b0; bus.req0_angle = '0;
        bus.req1_valid = 1'b0; bus.req1_angle = '0;
`ifdef CORDIC_SWEEP_EN
        bus.sweep_start = 1'b0;
`endif
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_phase", 64'(bus.phase), 64'h0);
        check("rst_phase_vld", 64'(bus.phase_vld), 64'h0);
        check("rst_rsp0", 64'(bus.rsp0_valid), 64'h0);
        check("rst_rsp1", 64'(bus.rsp1_valid), 64'h0);
        check("rst_rsp_sin", 64'(bus.rsp_sin), 64'h0);
        check("rst_rsp_cos", 64'(bus.rsp_cos), 64'h0);

        // Single ch0 request, 135 degrees
        clear_log();
        bus.req0_valid = 1'b1; bus.req0_angle = 9'd135;
        #1;
        t = cyc;
        check("t1_ready0", 64'(bus.req0_ready), 64'h1);
        check("t1_ready1", 64'(bus.req1_ready), 64'h0);
        tick(1);
        bus.req0_valid = 1'b0;
        check("t1_phase", 64'(bus.phase), 64'h1002D);
        check("t1_phase_vld", 64'(bus.phase_vld), 64'h1);
        tick(1);
        check("t1_phase_vld_off", 64'(bus.phase_vld), 64'h0);
        check("t1_phase_hold", 64'(bus.phase), 64'h1002D);
        tick(20);
        check("t1_rsp_count", 64'(rsp_cyc.size()), 64'd1);
        if (rsp_cyc.size() == 1) begin
            check("t1_rsp_tag", 64'(rsp_tag[0]), 64'd0);
            check("t1_rsp_cycle", 64'(rsp_cyc[0]), 64'(t + 18));
            check("t1_rsp_sin", 64'(rsp_dat[0]), 64'h1002D);
            check("t1_rsp_cos", 64'(rsp_cs[0]), 64'hFFFE_FFD2);
        end
        check("t1_sin_hold", 64'(bus.rsp_sin), 64'h1002D);

        // Both channels continuously valid: ch0 wins the first tie after reset, then alternate
        do_reset();
        clear_log();
        bus.req0_valid = 1'b1; bus.req0_angle = 9'd10;
        bus.req1_valid = 1'b1; bus.req1_angle = 9'd200;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) t = cyc;
            check($sformatf("t2_ready0_%0d", i), 64'(bus.req0_ready), 64'(i % 2 == 0));
            check($sformatf("t2_ready1_%0d", i), 64'(bus.req1_ready), 64'(i % 2 == 1));
            tick(1);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick(22);
        check("t2_rsp_count", 64'(rsp_cyc.size()), 64'd8);
        if (rsp_cyc.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("t2_tag_%0d", k), 64'(rsp_tag[k]), 64'(k % 2));
                check($sformatf("t2_cyc_%0d", k), 64'(rsp_cyc[k]), 64'(t + 18 + k));
                check($sformatf("t2_dat_%0d", k), 64'(rsp_dat[k]),
                      (k % 2 == 0) ? 64'h0000A : 64'h20014);
            end
        end

        // Boundary angles, back to back on ch0
        clear_log();
        ang    = '{9'd0, 9'd90, 9'd91, 9'd180, 9'd181, 9'd270, 9'd271, 9'd359, 9'd360, 9'd511};
        exp_ph = '{18'h00000, 18'h0005A, 18'h10001, 18'h1005A, 18'h20001,
                   18'h2005A, 18'h30001, 18'h30059, 18'h00000, 18'h1003D};
        for (int i = 0; i < 10; i++) begin
            bus.req0_valid = 1'b1; bus.req0_angle = ang[i];
            tick(1);
            check($sformatf("t3_phase_%0d", ang[i]), 64'(bus.phase), 64'(exp_ph[i]));
            check($sformatf("t3_vld_%0d", ang[i]), 64'(bus.phase_vld), 64'h1);
        end
        bus.req0_valid = 1'b0;
        tick(20);
        check("t3_rsp_count", 64'(rsp_cyc.size()), 64'd10);
        check("t3_last_sin", 64'(bus.rsp_sin), 64'h1003D);

        // Reset while five requests are in flight
        clear_log();
        for (int i = 0; i < 5; i++) begin
            bus.req0_valid = 1'b1; bus.req0_angle = 9'(i + 1);
            tick(1);
        end
        bus.req0_valid = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t4_phase", 64'(bus.phase), 64'h0);
        check("t4_phase_vld", 64'(bus.phase_vld), 64'h0);
        check("t4_rsp0", 64'(bus.rsp0_valid), 64'h0);
        check("t4_rsp1", 64'(bus.rsp1_valid), 64'h0);
        check("t4_rsp_sin", 64'(bus.rsp_sin), 64'h0);
        check("t4_rsp_cos", 64'(bus.rsp_cos), 64'h0);
        tick(25);
        check("t4_no_rsp", 64'(rsp_cyc.size()), 64'd0);
        bus.req0_valid = 1'b1; bus.req0_angle = 9'd45;
        #1;
        t = cyc;
        tick(1);
        bus.req0_valid = 1'b0;
        tick(20);
        check("t4_after_count", 64'(rsp_cyc.size()), 64'd1);
        if (rsp_cyc.size() == 1) begin
            check("t4_after_cyc", 64'(rsp_cyc[0]), 64'(t + 18));
            check("t4_after_sin", 64'(rsp_dat[0]), 64'h0002D);
        end

        // ch0 held waiting while ch1 wins the tie (ch0 was granted last)
        clear_log();
        bus.req0_valid = 1'b1; bus.req0_angle = 9'd300;
        bus.req1_valid = 1'b1; bus.req1_angle = 9'd45;
        #1;
        check("t5_ready0_wait", 64'(bus.req0_ready), 64'h0);
        check("t5_ready1", 64'(bus.req1_ready), 64'h1);
        tick(1);
        bus.req1_valid = 1'b0;
        #1;
        check("t5_ready0_go", 64'(bus.req0_ready), 64'h1);
        check("t5_phase_ch1", 64'(bus.phase), 64'h0002D);
        tick(1);
        bus.req0_valid = 1'b0;
        check("t5_phase_ch0", 64'(bus.phase), 64'h3001E);
        tick(1);
        check("t5_idle_vld", 64'(bus.phase_vld), 64'h0);
        tick(22);
        check("t5_rsp_count", 64'(rsp_cyc.size()), 64'd2);
        if (rsp_cyc.size() == 2) begin
            check("t5_first_tag", 64'(rsp_tag[0]), 64'd1);
            check("t5_first_sin", 64'(rsp_dat[0]), 64'h0002D);
            check("t5_second_tag", 64'(rsp_tag[1]), 64'd0);
            check("t5_second_sin", 64'(rsp_dat[1]), 64'h3001E);
            check("t5_spacing", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'd1);
        end

`ifdef CORDIC_SWEEP_EN
        // Full sweep with a ch0 preemption and an ignored second start
        clear_log();
        bus.sweep_start = 1'b1;
        tick(1);
        bus.sweep_start = 1'b0;
        check("sw_busy_start", 64'(bus.sweep_busy), 64'h1);
        done    = 1'b0;
        low_cyc = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            tick(1);
            if (k == 50) bus.sweep_start = 1'b1;
            if (k == 51) bus.sweep_start = 1'b0;
            if (k == 100) begin
                bus.req0_valid = 1'b1; bus.req0_angle = 9'd135;
                #1;
                check("sw_preempt_ready", 64'(bus.req0_ready), 64'h1);
            end
            if (k == 101) begin
                bus.req0_valid = 1'b0;
                check("sw_preempt_phase", 64'(bus.phase), 64'h1002D);
            end
            if (!bus.sweep_busy) begin
                done    = 1'b1;
                low_cyc = cyc;
            end
        end
        check("sw_finished", 64'(done), 64'h1);
        tick(5);
        n_sw = 0; bad_sw = 0; last_sw = 0; n_r0 = 0;
        foreach (rsp_tag[i]) begin
            if (rsp_tag[i] == 2) begin
                if (rsp_dat[i] !== model_phase(n_sw)) bad_sw++;
                n_sw++;
                last_sw = rsp_cyc[i];
            end else if (rsp_tag[i] == 0) begin
                n_r0++;
            end
        end
        check("sw_count", 64'(n_sw), 64'd360);
        check("sw_order_errors", 64'(bad_sw), 64'd0);
        check("sw_ch0_count", 64'(n_r0), 64'd1);
        check("sw_busy_drop", 64'(low_cyc), 64'(last_sw + 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
